// File: rtl/retro16_mem_pkg.sv
// Shared types and defaults for the retro16 memory controller.
// The beat helpers split a CPU word into SRAM-sized transfers.
package retro16_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    IO_WAIT,
    DONE
  } state_t;

  localparam logic [15:0] DEFAULT_IO_BASE    = 16'hC000;
  localparam int          DEFAULT_IO_TIMEOUT = 255;

  function automatic int calc_beats(input int data_w, input int sram_dw);
    return data_w / sram_dw;
  endfunction

  // The beat counter keeps at least one bit, even when a word needs a single beat.
  function automatic int calc_beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/io_bridge.sv
// I/O window handshake: holds the read or write strobe until io_ack arrives
// or the timeout budget runs out, and reports the outcome in that same cycle.
module io_bridge
  import retro16_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int IO_TIMEOUT = DEFAULT_IO_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_rd,
  output logic              io_wr,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             busy;

  assign busy    = io_rd | io_wr;
  assign done    = busy && (io_ack || cnt == CNT_W'(IO_TIMEOUT - 1));
  assign timeout = !io_ack;
  assign result  = io_ack ? io_rdata : '1;

  // The strobe is high for at most IO_TIMEOUT cycles; cnt counts the elapsed ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_addr  <= '0;
      io_wdata <= '0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      io_addr  <= addr;
      io_wdata <= wdata;
      io_rd    <= !write;
      io_wr    <= write;
      cnt      <= '0;
    end else if (done) begin
      io_rd <= 1'b0;
      io_wr <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// CPU-to-async-SRAM controller with an I/O window above IO_BASE.
// A word is moved as BEATS SRAM transfers, most significant lane first.
module sram_controller
  import retro16_mem_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter int                SRAM_DW     = 8,
  parameter int                SRAM_AW     = 21,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(DEFAULT_IO_BASE),
  parameter int                IO_TIMEOUT  = DEFAULT_IO_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               read_en,
  input  logic               write_en,
  output logic               ready,
  output logic [DATA_W-1:0]  data_out,
  output logic               ack,
  output logic               err,
  output logic [ADDR_W-1:0]  io_addr,
  output logic [DATA_W-1:0]  io_wdata,
  output logic               io_rd,
  output logic               io_wr,
  input  logic [DATA_W-1:0]  io_rdata,
  input  logic               io_ack,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [SRAM_DW-1:0] sram_data,
  output logic               sram_ce_inv,
  output logic               sram_oe_inv,
  output logic               sram_we_inv
);

  localparam int BEATS  = calc_beats(DATA_W, SRAM_DW);
  localparam int BEAT_W = calc_beat_w(BEATS);
  localparam int KW     = $clog2(BEATS);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              is_write;
  logic              err_r;
  logic [3:0]        ws_cnt;
  logic [BEAT_W-1:0] beat;
  logic              drive_bus;
  logic              accept, io_start, last_ws, last_beat;
  logic              io_done, io_timeout;
  logic [DATA_W-1:0] io_result;

  assign accept    = (state == IDLE) && (read_en || write_en);
  assign io_start  = accept && (addr_in >= IO_BASE);
  assign last_ws   = (ws_cnt == 4'(WAIT_STATES));
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign sram_data = drive_bus ? wdata_r[DATA_W-1 -: SRAM_DW] : 'z;

  io_bridge #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .IO_TIMEOUT (IO_TIMEOUT)
  ) u_io_bridge (
    .clk      (clk),
    .rst      (rst),
    .start    (io_start),
    .write    (write_en),
    .addr     (addr_in),
    .wdata    (data_in),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_rdata (io_rdata),
    .io_ack   (io_ack),
    .done     (io_done),
    .timeout  (io_timeout),
    .result   (io_result)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Write data shifts out MSB-first; read data shifts in at the LSB so beat 0 ends up on top.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r   <= '0;
      wdata_r  <= '0;
      is_write <= 1'b0;
      data_out <= '0;
      err_r    <= 1'b0;
      ws_cnt   <= '0;
      beat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_r   <= addr_in;
            wdata_r  <= data_in;
            is_write <= write_en;
            err_r    <= 1'b0;
            ws_cnt   <= '0;
            beat     <= '0;
          end
        end
        STROBE: begin
          if (last_ws) begin
            ws_cnt <= '0;
            beat   <= beat + BEAT_W'(1);
            if (is_write) wdata_r <= wdata_r << SRAM_DW;
            else          data_out <= (data_out << SRAM_DW) | DATA_W'(sram_data);
          end else begin
            ws_cnt <= ws_cnt + 4'd1;
          end
        end
        IO_WAIT: begin
          if (io_done) begin
            data_out <= io_result;
            err_r    <= io_timeout;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    ready       = 1'b0;
    ack         = 1'b0;
    err         = 1'b0;
    sram_ce_inv = 1'b1;
    sram_oe_inv = 1'b1;
    sram_we_inv = 1'b1;
    sram_addr   = '0;
    drive_bus   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) next_state = io_start ? IO_WAIT : SETUP;
      end
      SETUP: begin
        sram_ce_inv = 1'b0;
        sram_addr   = (SRAM_AW'(addr_r) << KW) | SRAM_AW'(beat);
        drive_bus   = is_write;
        next_state  = STROBE;
      end
      STROBE: begin
        sram_ce_inv = 1'b0;
        sram_oe_inv = is_write;
        sram_we_inv = !is_write;
        sram_addr   = (SRAM_AW'(addr_r) << KW) | SRAM_AW'(beat);
        drive_bus   = is_write;
        if (last_ws) next_state = last_beat ? DONE : SETUP;
      end
      IO_WAIT: begin
        if (io_done) next_state = DONE;
      end
      DONE: begin
        ack        = 1'b1;
        err        = err_r;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a byte-wide SRAM model and an I/O responder.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic        read_en;
  logic        write_en;
  logic        ready;
  logic [15:0] data_out;
  logic        ack;
  logic        err;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_rdata;
  logic        io_ack;
  logic [20:0] sram_addr;
  wire  [7:0]  sram_data;
  logic        sram_ce_inv;
  logic        sram_oe_inv;
  logic        sram_we_inv;

  logic [7:0]  mem [0:63];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk         (clk),
    .rst         (rst),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .read_en     (read_en),
    .write_en    (write_en),
    .ready       (ready),
    .data_out    (data_out),
    .ack         (ack),
    .err         (err),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_rd       (io_rd),
    .io_wr       (io_wr),
    .io_rdata    (io_rdata),
    .io_ack      (io_ack),
    .sram_addr   (sram_addr),
    .sram_data   (sram_data),
    .sram_ce_inv (sram_ce_inv),
    .sram_oe_inv (sram_oe_inv),
    .sram_we_inv (sram_we_inv)
  );

  // SRAM model: drives the bus while selected with output enabled, latches while write-enabled.
  assign sram_data = (!sram_ce_inv && !sram_oe_inv) ? mem[sram_addr[5:0]] : 'z;

  always @(posedge clk) begin
    if (!sram_ce_inv && !sram_we_inv) mem[sram_addr[5:0]] <= sram_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one accepted access until ack or the cycle limit; cycle 1 is the first cycle after the accept edge.
  task automatic run_access(input int limit, input int ack_at,
                            output int ack_cyc, output int we_low, output int oe_low,
                            output int io_hi, output logic [20:0] sa1,
                            output logic [20:0] sa4, output logic [15:0] dout,
                            output logic eflag);
    ack_cyc = -1;
    we_low  = 0;
    oe_low  = 0;
    io_hi   = 0;
    sa1     = '0;
    sa4     = '0;
    dout    = '0;
    eflag   = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        read_en  = 1'b0;
        write_en = 1'b0;
        addr_in  = 16'h5555;
        data_in  = 16'hFFFF;
        sa1      = sram_addr;
      end
      if (cyc == 4) sa4 = sram_addr;
      if (!sram_we_inv) we_low++;
      if (!sram_oe_inv) oe_low++;
      if (io_rd || io_wr) io_hi++;
      if (ack) begin
        ack_cyc = cyc;
        dout    = data_out;
        eflag   = err;
        io_ack  = 1'b0;
        break;
      end
      if (cyc == ack_at) io_ack = 1'b1;
    end
  endtask

  int          ack_cyc, we_low, oe_low, io_hi, ack_seen;
  logic [20:0] sa1, sa4;
  logic [15:0] dout;
  logic        eflag;

  initial begin
    rst      = 1'b1;
    addr_in  = '0;
    data_in  = '0;
    read_en  = 1'b0;
    write_en = 1'b0;
    io_rdata = '0;
    io_ack   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dout", 32'(data_out), 32'h0);
    check("rst_io", 32'({io_rd, io_wr}), 32'd0);
    check("rst_saddr", 32'(sram_addr), 32'h0);
    check("rst_strobes", 32'({sram_ce_inv, sram_oe_inv, sram_we_inv}), 32'h7);
    rst = 1'b0;
    @(negedge clk);

    // Write 0x1234 to word 0x0010
    addr_in  = 16'h0010;
    data_in  = 16'h1234;
    write_en = 1'b1;
    run_access(20, -1, ack_cyc, we_low, oe_low, io_hi, sa1, sa4, dout, eflag);
    check("wr_ack_cycle", 32'(ack_cyc), 32'd7);
    check("wr_we_low", 32'(we_low), 32'd4);
    check("wr_oe_low", 32'(oe_low), 32'd0);
    check("wr_addr_b0", 32'(sa1), 32'h20);
    check("wr_addr_b1", 32'(sa4), 32'h21);
    check("wr_err", 32'(eflag), 32'd0);
    check("wr_mem20", 32'(mem[6'h20]), 32'h12);
    check("wr_mem21", 32'(mem[6'h21]), 32'h34);
    @(negedge clk);
    check("wr_ready_after", 32'(ready), 32'd1);

    // Read the word back
    addr_in = 16'h0010;
    read_en = 1'b1;
    run_access(20, -1, ack_cyc, we_low, oe_low, io_hi, sa1, sa4, dout, eflag);
    check("rd_ack_cycle", 32'(ack_cyc), 32'd7);
    check("rd_data", 32'(dout), 32'h1234);
    check("rd_oe_low", 32'(oe_low), 32'd4);
    check("rd_we_low", 32'(we_low), 32'd0);
    check("rd_err", 32'(eflag), 32'd0);
    @(negedge clk);

    // I/O read acknowledged on the third strobe cycle
    addr_in  = 16'hC004;
    read_en  = 1'b1;
    io_rdata = 16'hBEEF;
    run_access(20, 3, ack_cyc, we_low, oe_low, io_hi, sa1, sa4, dout, eflag);
    check("io_rd_cycles", 32'(io_hi), 32'd3);
    check("io_ack_cycle", 32'(ack_cyc), 32'd4);
    check("io_rd_data", 32'(dout), 32'hBEEF);
    check("io_rd_err", 32'(eflag), 32'd0);
    check("io_rd_addr", 32'(io_addr), 32'hC004);
    check("io_no_sram", 32'(oe_low), 32'd0);
    @(negedge clk);

    // I/O read that is never acknowledged
    addr_in = 16'hFFFE;
    read_en = 1'b1;
    run_access(400, -1, ack_cyc, we_low, oe_low, io_hi, sa1, sa4, dout, eflag);
    check("to_rd_cycles", 32'(io_hi), 32'd255);
    check("to_ack_cycle", 32'(ack_cyc), 32'd256);
    check("to_data", 32'(dout), 32'hFFFF);
    check("to_err", 32'(eflag), 32'd1);
    @(negedge clk);

    // Window boundary: IO_BASE-1 is SRAM, IO_BASE is I/O
    addr_in = 16'hBFFF;
    read_en = 1'b1;
    run_access(20, -1, ack_cyc, we_low, oe_low, io_hi, sa1, sa4, dout, eflag);
    check("bnd_sram_addr", 32'(sa1), 32'h17FFE);
    check("bnd_sram_noio", 32'(io_hi), 32'd0);
    check("bnd_sram_ack", 32'(ack_cyc), 32'd7);
    @(negedge clk);
    addr_in  = 16'hC000;
    data_in  = 16'h0F0F;
    write_en = 1'b1;
    run_access(20, 1, ack_cyc, we_low, oe_low, io_hi, sa1, sa4, dout, eflag);
    check("bnd_io_wr_cycles", 32'(io_hi), 32'd1);
    check("bnd_io_ack", 32'(ack_cyc), 32'd2);
    check("bnd_io_wdata", 32'(io_wdata), 32'h0F0F);
    check("bnd_io_addr", 32'(io_addr), 32'hC000);
    check("bnd_io_err", 32'(eflag), 32'd0);
    check("bnd_io_sram_idle", 32'(we_low), 32'd0);
    @(negedge clk);

    // Read and write together, aborted by reset during the second beat
    addr_in  = 16'h0001;
    data_in  = 16'hA55A;
    read_en  = 1'b1;
    write_en = 1'b1;
    @(negedge clk);
    read_en  = 1'b0;
    write_en = 1'b0;
    check("both_setup_ce", 32'(sram_ce_inv), 32'd0);
    @(negedge clk);
    check("both_is_write", 32'({sram_oe_inv, sram_we_inv}), 32'h2);
    repeat (2) @(negedge clk);
    check("both_addr_b1", 32'(sram_addr), 32'h3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_strobes", 32'({sram_ce_inv, sram_oe_inv, sram_we_inv}), 32'h7);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_dout", 32'(data_out), 32'h0);
    rst      = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) ack_seen++;
    end
    check("abort_no_ack", 32'(ack_seen), 32'd0);
    check("abort_beat0", 32'(mem[6'h02]), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
